// File: rtl/fifo_uart_tx_if.sv
// FIFO read side and serial output of fifo_uart_tx, bundled for port connection.
// master: the serialiser; slave: the FIFO / pin side that observes it.
interface fifo_uart_tx_if;
  logic       empty;
  logic [7:0] fifo_data;
  logic       read_en;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    input  empty,
    input  fifo_data,
    output read_en,
    output tx,
    output busy,
    output frame_done
  );

  modport slave (
    output empty,
    output fifo_data,
    input  read_en,
    input  tx,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and serialises them as UART frames
// (start, 8 data LSB first, optional even parity when PARITY_EN is defined, stop).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic           clk,
  input  logic           reset,
  fifo_uart_tx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(CLKS_PER_BIT - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             read_en_q, read_en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             bit_end;
`ifdef PARITY_EN
  logic             par_q, par_d;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      read_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      read_en_q    <= read_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    read_en_d    = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
`ifdef PARITY_EN
    par_d        = par_q;
`endif
    bit_end      = (cnt_q == CNT_LAST);

    // Baud counter runs only while a bit is on the line; it wraps at each bit boundary.
    if (state_q != IDLE && state_q != POP && state_q != LATCH) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!bus.empty) begin
          state_d   = POP;
          read_en_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      POP: state_d = LATCH;
      LATCH: begin
        shift_d = bus.fifo_data;
`ifdef PARITY_EN
        par_d   = even_parity(bus.fifo_data);
`endif
        tx_d    = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        // Registered pulse: set one cycle early so it shows in the final stop cycle.
        if (cnt_q == CNT_PEN) frame_done_d = 1'b1;
        if (bit_end) begin
          if (!bus.empty) begin
            state_d   = POP;
            read_en_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx         = tx_q;
  assign bus.read_en    = read_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule
